// File: rtl/sfifo_wr_arb.sv
// -----------------------------------------------------------------------------
// sfifo_wr_arb
//   Round-robin write arbiter that shares one sfifo write port among NUM_REQ
//   producers. Each grant lets a producer push a burst of up to MAX_BURST words
//   over a valid/ready handshake. A local credit counter mirrors the free space
//   of the downstream fifo, so a word is never issued into a full fifo.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no owner active; arbitrate among valid producers (ready all-zero)
//   BURST | owner may push words while credits remain; released on last beat
//         | or when the owner drops valid
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-low
//   req_valid   per-producer valid
//   req_data    producer i data at [i*DATA_W +: DATA_W]
//   req_ready   per-producer ready (combinational, only the owner in BURST)
//   fifo_w_en   registered write strobe to the fifo
//   fifo_din    registered write data to the fifo
//   fifo_rd     one pulse per word popped from the fifo (returns a credit)
//   credits     free fifo words as tracked here
//   owner       current / last granted producer index
//   busy        high while in BURST
//   err_credit  sticky flag: a pop was reported while credits were full
// -----------------------------------------------------------------------------
module sfifo_wr_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int OW = $clog2(NUM_REQ),
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        fifo_w_en,
  output logic [DATA_W-1:0]           fifo_din,
  input  logic                        fifo_rd,
  output logic [CW-1:0]               credits,
  output logic [OW-1:0]               owner,
  output logic                        busy,
  output logic                        err_credit
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_next;
  logic [OW-1:0]   owner_next;
  logic [BW-1:0]   beat_cnt, beat_next;
  logic [CW-1:0]   credits_next;
  logic [OW-1:0]   pick;
  logic            pick_found;
  logic            xfer;
  logic            credit_ret;
  logic            credit_avail;
  logic            credits_full;
  logic [DATA_W-1:0] owner_data;

  assign credit_avail = (credits != '0);
  assign credits_full = (credits == CW'(DEPTH));
  // A pop at full credits cannot be real; it is dropped and flagged.
  assign credit_ret   = fifo_rd && !credits_full;
  assign owner_data   = req_data[int'(owner)*DATA_W +: DATA_W];
  assign busy         = (state == BURST);

  // Cyclic search starting one past the last owner, so the pointer only
  // moves on a grant and every producer is reached within NUM_REQ grants.
  always_comb begin
    pick       = owner;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(owner) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = OW'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    beat_next  = beat_cnt;
    req_ready  = '0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found && credit_avail) begin
          owner_next = pick;
          beat_next  = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        req_ready[owner] = credit_avail;
        xfer             = req_valid[owner] && credit_avail;
        if (xfer) beat_next = beat_cnt + BW'(1);
        if ((xfer && beat_cnt == BW'(MAX_BURST - 1)) || !req_valid[owner])
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    credits_next = credits;
    case ({xfer, credit_ret})
      2'b10:   credits_next = credits - CW'(1);
      2'b01:   credits_next = credits + CW'(1);
      default: credits_next = credits;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      credits    <= CW'(DEPTH);
      fifo_w_en  <= 1'b0;
      fifo_din   <= '0;
      err_credit <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      beat_cnt  <= beat_next;
      credits   <= credits_next;
      fifo_w_en <= xfer;
      if (xfer) fifo_din <= owner_data;
      if (fifo_rd && credits_full) err_credit <= 1'b1;
    end
  end

endmodule
